// File: rtl/mem_slot_arbiter_pkg.sv
// Shared constants and the slot ownership table for the memory slot arbiter.
// Latency: combinational helpers only.
// Backpressure: none; this package only holds types and functions.
package mem_arb_pkg;

    // Requester IDs, as they appear on GNT_ID and as bit positions of REQ/ACK.
    localparam logic [1:0] REQ_SPR = 2'd0;
    localparam logic [1:0] REQ_FIX = 2'd1;
    localparam logic [1:0] REQ_68K = 2'd2;
    localparam logic [1:0] REQ_Z80 = 2'd3;

    // Owner code for slots that belong to the 68K/Z80 round-robin pool.
    // It shares its value with REQ_68K, so callers test bit 1 to tell a
    // pool slot from a fixed slot (fixed owners are 0 and 1 only).
    localparam logic [1:0] OWN_POOL = 2'b10;

    // Even slots alternate sprite / fix fetch; odd slots go to the pool.
    function automatic logic [1:0] slot_owner(input logic [2:0] slot);
        logic [1:0] own;
        case (slot)
            3'd0, 3'd4: own = REQ_SPR;
            3'd2, 3'd6: own = REQ_FIX;
            default:    own = OWN_POOL;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/mem_slot_arbiter_rr2.sv
// Two-way round-robin picker between the 68K and the Z80.
// Latency: winner/valid are combinational; the pointer updates on the next CLK.
// Backpressure: the pointer only moves when advance_i says the pick was used.
//
// Ports: clk_i/rst_i (sync active-high), req_i[1:0] (bit0 = 68K, bit1 = Z80),
//        advance_i (pick consumed), winner_o (0 = 68K, 1 = Z80), valid_o.
module mem_arb_rr2 #(
    parameter logic START = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       winner_o,
    output logic       valid_o
);

    // ptr_q names the side that wins a tie.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        valid_o  = |req_i;
        winner_o = (req_i == 2'b11) ? ptr_q : req_i[1];
        ptr_d    = ptr_q;
        // Tie or single request: priority always passes to the loser.
        if (advance_i && valid_o) begin
            ptr_d = ~winner_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= START;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_slot_arbiter.sv
// Time-slot arbiter sharing one memory port between sprite, fix, 68K and Z80.
// Latency: slot enable -> MEM_START 1 CLK; MEM_DONE -> ACK/RDATA 1 CLK.
// Backpressure: one access in flight; a slot that finds the port busy is lost.
//
// Ports: CLK/RESETP (sync active-high), CLK_EN_24M_N slot advance, SYNC frame
//        realign, REQ/REQ_WE/REQ_ADDR/REQ_WDATA per-requester bus, ACK/RDATA
//        completion, MEM_* single-beat memory port, SLOT and GNT_ID debug.
module mem_slot_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int RR_START = 2
) (
    input  logic            CLK,
    input  logic            RESETP,
    input  logic            CLK_EN_24M_N,
    input  logic            SYNC,
    input  logic [3:0]      REQ,
    input  logic [3:0]      REQ_WE,
    input  logic [4*AW-1:0] REQ_ADDR,
    input  logic [4*DW-1:0] REQ_WDATA,
    output logic [3:0]      ACK,
    output logic [DW-1:0]   RDATA,
    output logic            MEM_START,
    output logic            MEM_WE,
    output logic [AW-1:0]   MEM_ADDR,
    output logic [DW-1:0]   MEM_WDATA,
    input  logic [DW-1:0]   MEM_RDATA,
    input  logic            MEM_DONE,
    output logic [2:0]      SLOT,
    output logic [1:0]      GNT_ID
);

    logic [2:0]    slot_q,  slot_d;
    logic          busy_q,  busy_d;
    logic [3:0]    ack_q,   ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          start_q, start_d;
    logic          we_q,    we_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [1:0]    gnt_q,   gnt_d;
    logic [7:0]    skip_q,  skip_d;

    logic [3:0] in_flight;
    logic [3:0] eligible;
    logic [1:0] owner;
    logic [1:0] win_id;
    logic       fixed_hit;
    logic       pool_win;
    logic       pool_vld;
    logic       any_elig;
    logic       grant;
    logic       done;

    // A requester is not eligible while its access is outstanding, nor in
    // the ACK cycle itself, when its REQ is legitimately still high.
    assign in_flight = ack_q | (busy_q ? (4'b0001 << gnt_q) : 4'b0000);
    assign eligible  = REQ & ~in_flight;

    assign owner     = slot_owner(slot_q);
    assign fixed_hit = ~owner[1] & eligible[owner];
    assign any_elig  = fixed_hit | pool_vld;
    assign grant     = CLK_EN_24M_N & ~busy_q & any_elig;
    assign done      = MEM_DONE & busy_q;
    assign win_id    = fixed_hit ? owner : {1'b1, pool_win};

    // Consulted on every slot so an idle fixed slot falls through to the pool;
    // the pointer only moves when the pool actually receives the grant.
    mem_arb_rr2 #(
        .START (RR_START == 3)
    ) u_rr (
        .clk_i     (CLK),
        .rst_i     (RESETP),
        .req_i     (eligible[3:2]),
        .advance_i (grant & ~fixed_hit),
        .winner_o  (pool_win),
        .valid_o   (pool_vld)
    );

    always_comb begin
        slot_d  = slot_q;
        busy_d  = busy_q;
        ack_d   = 4'b0000;
        rdata_d = rdata_q;
        start_d = grant;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = gnt_q;
        skip_d  = skip_q;

        // Realign touches only the counter; arbitration above used the old slot.
        if (CLK_EN_24M_N) begin
            slot_d = SYNC ? 3'd0 : slot_q + 3'd1;
        end

        // grant needs busy_q=0 and done needs busy_q=1, so they never collide.
        if (grant) begin
            busy_d  = 1'b1;
            we_d    = REQ_WE[win_id];
            addr_d  = REQ_ADDR[win_id*AW +: AW];
            wdata_d = REQ_WDATA[win_id*DW +: DW];
            gnt_d   = win_id;
        end else if (done) begin
            busy_d  = 1'b0;
            ack_d   = 4'b0001 << gnt_q;
            rdata_d = MEM_RDATA;
        end

        // A slot that someone wanted but could not use is dropped, not queued.
        if (CLK_EN_24M_N && busy_q && any_elig && (skip_q != 8'hFF)) begin
            skip_d = skip_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETP) begin
            slot_q  <= 3'd0;
            busy_q  <= 1'b0;
            ack_q   <= 4'b0000;
            rdata_q <= '0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= 2'd0;
            skip_q  <= 8'd0;
        end else begin
            slot_q  <= slot_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            start_q <= start_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            skip_q  <= skip_d;
        end
    end

    assign ACK       = ack_q;
    assign RDATA     = rdata_q;
    assign MEM_START = start_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign SLOT      = slot_q;
    assign GNT_ID    = gnt_q;

endmodule
